// File: rtl/count_display_scanner.sv
// count_display_scanner: captures a stream of 4-bit counts into a digit
// history (digit 0 = newest) and time-multiplexes that history onto a
// common-anode 7-segment bank with one-hot, active-low digit enables.

// One history digit: cleared by reset or clear, loads its neighbour on shift.
module cds_digit_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       shift,
  input  logic [3:0] d,
  output logic [3:0] q
);
  // clear beats shift so a clear+valid cycle leaves the digit at zero
  always_ff @(posedge clk) begin
    if (!rst_n || clear) q <= 4'h0;
    else if (shift)      q <= d;
  end
endmodule

module count_display_scanner #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 1000,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            count_i,
  input  logic                  valid_i,
  input  logic                  clear_i,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  full_o
);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(NUM_DIGITS + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(NUM_DIGITS);
  localparam logic [SW-1:0] SCAN_MAX = SW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]    BLANK    = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;

  logic [NUM_DIGITS-1:0][3:0] buffer;
  logic [FW-1:0]              fill, fill_nxt;
  logic [SW-1:0]              scan;
  logic [PW-1:0]              pre;
  logic [6:0]                 seg_nxt;
  logic [NUM_DIGITS-1:0]      an_nxt;
  logic [3:0]                 sel_digit;
  logic                       sel_valid;

  // Shift chain: digit 0 takes the new count, each older digit its younger
  // neighbour; the oldest digit simply falls off the end.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] d_in;
    if (g == 0) begin : g_head
      assign d_in = count_i;
    end else begin : g_tail
      assign d_in = buffer[g-1];
    end
    cds_digit_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_i),
      .shift (valid_i),
      .d     (d_in),
      .q     (buffer[g])
    );
  end

  // Fill level: saturating count of captured digits, zeroed by clear.
  always_comb begin
    fill_nxt = fill;
    if (clear_i)                         fill_nxt = '0;
    else if (valid_i && fill != FILL_MAX) fill_nxt = fill + 1'b1;
  end

  // fill and full_o move together so full_o is high the cycle after the
  // push that completes the history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill   <= '0;
      full_o <= 1'b0;
    end else begin
      fill   <= fill_nxt;
      full_o <= (fill_nxt == FILL_MAX);
    end
  end

  // Refresh prescaler and digit select; free-running regardless of history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre  <= '0;
      scan <= '0;
    end else if (pre == PRE_MAX) begin
      pre  <= '0;
      scan <= (scan == SCAN_MAX) ? '0 : scan + 1'b1;
    end else begin
      pre  <= pre + 1'b1;
    end
  end

  // Decode the selected digit; digits beyond the fill level show blank.
  always_comb begin
    sel_digit = buffer[scan];
    sel_valid = (FW'(scan) < fill);
    seg_nxt   = 7'h00;
    if (sel_valid) begin
      case (sel_digit)
        4'h0: seg_nxt = 7'h3F;
        4'h1: seg_nxt = 7'h06;
        4'h2: seg_nxt = 7'h5B;
        4'h3: seg_nxt = 7'h4F;
        4'h4: seg_nxt = 7'h66;
        4'h5: seg_nxt = 7'h6D;
        4'h6: seg_nxt = 7'h7D;
        4'h7: seg_nxt = 7'h07;
        4'h8: seg_nxt = 7'h7F;
        4'h9: seg_nxt = 7'h6F;
        4'hA: seg_nxt = 7'h77;
        4'hB: seg_nxt = 7'h7C;
        4'hC: seg_nxt = 7'h39;
        4'hD: seg_nxt = 7'h5E;
        4'hE: seg_nxt = 7'h79;
        default: seg_nxt = 7'h71;
      endcase
    end
    if (ACTIVE_LOW_SEG != 0) seg_nxt = ~seg_nxt;
    an_nxt = ~(NUM_DIGITS'(1) << scan);
  end

  // Registered pin stage: glitch-free outputs, one cycle behind scan/buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_o  <= '1;
      seg_o <= BLANK;
    end else begin
      an_o  <= an_nxt;
      seg_o <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_count_display_scanner.sv
// Bench for count_display_scanner: directed scenarios with literal checks,
// then random traffic, all continuously compared against a history model.
module tb_count_display_scanner;
  localparam int N  = 8;
  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count_i = 4'h0;
  logic       valid_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [6:0] seg_o;
  logic [7:0] an_o;
  logic       full_o;

  count_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW_SEG(1)) dut (
    .clk(clk), .rst_n(rst_n), .count_i(count_i), .valid_i(valid_i),
    .clear_i(clear_i), .seg_o(seg_o), .an_o(an_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Active-high abcdefg codes; lit segment drives 0 on the pins.
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // History model: plain array + fill count; the selected digit is derived
  // from the number of clocks since reset.
  int         m_hist [N];
  int         m_fill  = 0;
  int         m_ticks = 0;
  int         m_s;
  logic [7:0] exp_an   = 8'hFF;
  logic [6:0] exp_seg  = 7'h7F;
  logic       exp_full = 1'b0;
  bit         chk_en   = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_hist[i]) m_hist[i] = 0;
      m_fill = 0; m_ticks = 0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_full = 1'b0;
    end else begin
      m_s     = (m_ticks / RD) % N;
      exp_an  = ~(8'h01 << m_s);
      exp_seg = (m_s < m_fill) ? ~hex_tbl[m_hist[m_s]] : 7'h7F;
      if (clear_i) begin
        foreach (m_hist[i]) m_hist[i] = 0;
        m_fill = 0;
      end else if (valid_i) begin
        for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'(count_i);
        if (m_fill < N) m_fill++;
      end
      exp_full = (m_fill == N);
      m_ticks++;
    end
    chk_en = 1'b1;
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_an",   32'(an_o),   32'(exp_an));
      chk("model_seg",  32'(seg_o),  32'(exp_seg));
      chk("model_full", 32'(full_o), 32'(exp_full));
    end
  end

  task automatic wait_an(input logic [7:0] a, input string nm);
    int n = 0;
    while (an_o !== a && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (an_o !== a) chk(nm, 32'(an_o), 32'(a));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [8] = '{1, 8, 5, 2, 1, 5, 2, 2};
    int changes;
    logic [7:0] pv;

    // 1: reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an",   32'(an_o),   32'h0FF);
    chk("rst_seg",  32'(seg_o),  32'h07F);
    chk("rst_full", 32'(full_o), 32'h0);
    rst_n = 1'b1;

    // 2: eight pushes
    foreach (seq[k]) begin
      valid_i = 1'b1; count_i = 4'(seq[k]);
      @(negedge clk);
    end
    valid_i = 1'b0;
    chk("full_after8", 32'(full_o), 32'h1);
    @(negedge clk);
    wait_an(8'hFE, "wait_fe");
    chk("dig0_is_2", 32'(seg_o), 32'h24);
    wait_an(8'h7F, "wait_7f");
    chk("dig7_is_1", 32'(seg_o), 32'h79);

    // 3: ninth push drops the oldest digit
    valid_i = 1'b1; count_i = 4'h8;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    wait_an(8'hFE, "wait_fe9");
    chk("dig0_is_8", 32'(seg_o), 32'h00);
    wait_an(8'h7F, "wait_7f9");
    chk("dig7_is_8", 32'(seg_o), 32'h00);
    chk("full_stays", 32'(full_o), 32'h1);

    // 4: clear wins over a simultaneous push
    clear_i = 1'b1; valid_i = 1'b1; count_i = 4'h5;
    @(negedge clk);
    clear_i = 1'b0; valid_i = 1'b0;
    chk("clear_full", 32'(full_o), 32'h0);
    @(negedge clk);
    changes = 0; pv = an_o;
    repeat (40) begin
      chk("clear_blank", 32'(seg_o), 32'h07F);
      if (an_o != pv) changes++;
      pv = an_o;
      @(negedge clk);
    end
    chk("clear_scan_moves", 32'(changes >= 8), 32'h1);

    // 5: idle scan order and dwell
    begin
      int n = 0;
      pv = an_o;
      do begin
        pv = an_o;
        @(negedge clk);
        n++;
      end while (!(an_o == 8'hFE && pv != 8'hFE) && n < 64);
    end
    for (int i = 0; i < 9; i++)
      for (int c = 0; c < RD; c++) begin
        chk("scan_seq", 32'(an_o), 32'(8'(~(8'h01 << (i % N)))));
        @(negedge clk);
      end

    // random traffic, including clears and mid-run resets
    repeat (1500) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      valid_i = ($urandom_range(0, 2) == 0);
      clear_i = ($urandom_range(0, 40) == 0);
      count_i = 4'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1; valid_i = 1'b0; clear_i = 1'b0;

    // 6: reset while full with scan at digit 5
    for (int k = 0; k < N; k++) begin
      valid_i = 1'b1; count_i = 4'($urandom);
      @(negedge clk);
    end
    valid_i = 1'b0;
    wait_an(8'hDF, "wait_df");
    chk("full_before_rst", 32'(full_o), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_an",   32'(an_o),   32'h0FF);
    chk("mid_rst_seg",  32'(seg_o),  32'h07F);
    chk("mid_rst_full", 32'(full_o), 32'h0);
    rst_n = 1'b1; valid_i = 1'b1; count_i = 4'h3;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    wait_an(8'hFE, "wait_fe3");
    chk("dig0_is_3", 32'(seg_o), 32'h30);
    repeat (32) begin
      @(negedge clk);
      if (an_o == 8'hFE) chk("only_dig0", 32'(seg_o), 32'h30);
      else               chk("others_blank", 32'(seg_o), 32'h07F);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
